// File: rtl/mem_stage.sv
// EX/MEM latch, data-cache request/stall control and MEM/WB latch for the 5-stage pipeline.
// Optional MEM_ALIGN_CHECK_EN: suppress misaligned memory ops and flag them on a sticky misalign output.
module mem_stage #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              flush,
    input  logic [WORD_W-1:0] ex_ALUOut,
    input  logic [WORD_W-1:0] ex_rtdat,
    input  logic [WORD_W-1:0] ex_nPC,
    input  logic              ex_dREN,
    input  logic              ex_dWEN,
    input  logic              ex_regWr,
    input  logic              ex_halt,
    input  logic [2:0]        ex_regSel,
    input  logic [REG_W-1:0]  ex_regDst,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [REG_W-1:0]  fwd_regDst,
    output logic              fwd_regWr,
    output logic [WORD_W-1:0] fwd_data,
    output logic [WORD_W-1:0] wb_wdat,
    output logic [REG_W-1:0]  wb_regDst,
    output logic              wb_regWr,
    output logic              halt
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    typedef struct packed {
        logic [WORD_W-1:0] alu_out;
        logic [WORD_W-1:0] rtdat;
        logic [WORD_W-1:0] npc;
        logic              dren;
        logic              dwen;
        logic              regwr;
        logic              halt;
        logic [2:0]        regsel;
        logic [REG_W-1:0]  regdst;
    } m_latch_t;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_next;
    m_latch_t          m_q, m_in;
    logic [WORD_W-1:0] ldat_hold;
    logic [WORD_W-1:0] wdat_next;
    logic              w_halt;
    logic              adv;
    logic              in_mem;
    logic              ldat_cap;
`ifdef MEM_ALIGN_CHECK_EN
    logic              m_misal;
`endif

    // Stall/advance and the next M-latch contents (bubble on flush)
    always_comb begin
        mem_stall = (state == WAIT) & ~dhit;
        adv       = ihit & ~mem_stall;
        m_in      = '0;
        if (!flush) begin
            m_in.alu_out = ex_ALUOut;
            m_in.rtdat   = ex_rtdat;
            m_in.npc     = ex_nPC;
            m_in.dren    = ex_dREN;
            m_in.dwen    = ex_dWEN;
            m_in.regwr   = ex_regWr;
            m_in.halt    = ex_halt;
            m_in.regsel  = ex_regSel;
            m_in.regdst  = ex_regDst;
        end
`ifdef MEM_ALIGN_CHECK_EN
        in_mem  = (m_in.dren | m_in.dwen) & (m_in.alu_out[1:0] == 2'b00);
        m_misal = (m_q.dren | m_q.dwen) & (m_q.alu_out[1:0] != 2'b00);
`else
        in_mem  = m_in.dren | m_in.dwen;
`endif
    end

    // Access FSM next state and cache request outputs
    always_comb begin
        state_next = state;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        dmemaddr   = '0;
        dmemstore  = '0;
        ldat_cap   = 1'b0;
        case (state)
            IDLE: begin
                if (adv && in_mem) state_next = WAIT;
            end
            WAIT: begin
                dmemREN   = m_q.dren & ~halt;
                dmemWEN   = m_q.dwen & ~halt;
                dmemaddr  = m_q.alu_out;
                dmemstore = m_q.rtdat;
                if (dhit) begin
                    if (adv) begin
                        state_next = in_mem ? WAIT : IDLE;
                    end else begin
                        state_next = DONE;
                        ldat_cap   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (adv) state_next = in_mem ? WAIT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Writeback data select
    always_comb begin
        case (m_q.regsel)
            3'd1:    wdat_next = dhit ? dmemload : ldat_hold;
            3'd2:    wdat_next = m_q.npc;
            default: wdat_next = m_q.alu_out;
        endcase
    end

    assign fwd_regDst = m_q.regdst;
    assign fwd_regWr  = m_q.regwr & ~m_q.dren;
    assign fwd_data   = m_q.alu_out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            m_q       <= '0;
            ldat_hold <= '0;
            wb_wdat   <= '0;
            wb_regDst <= '0;
            wb_regWr  <= 1'b0;
            w_halt    <= 1'b0;
            halt      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            halt  <= halt | w_halt;
            if (ldat_cap) ldat_hold <= dmemload;
            if (adv) begin
                m_q       <= m_in;
                wb_wdat   <= wdat_next;
                wb_regDst <= m_q.regdst;
                w_halt    <= m_q.halt;
`ifdef MEM_ALIGN_CHECK_EN
                wb_regWr  <= m_q.regwr & ~m_misal;
                misalign  <= misalign | m_misal;
`else
                wb_regWr  <= m_q.regwr;
`endif
            end
        end
    end

endmodule
